// File: rtl/enigma_pkg.sv
// Shared types and constants for the parametrised two-rotor Enigma engine.
package enigma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StRun
    } state_e;

    // PermTab[m][k]: source offset within an 8-entry group for destination k.
    localparam logic [2:0] PermTab [8][8] = '{
        '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
        '{3'd1, 3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd7, 3'd6},
        '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5},
        '{3'd0, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd7},
        '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3},
        '{3'd5, 3'd6, 3'd7, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2},
        '{3'd6, 3'd7, 3'd3, 3'd2, 3'd5, 3'd4, 3'd0, 3'd1},
        '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}
    };

    function automatic bit w_legal(int unsigned w);
        return (w >= 3) && (w <= 8);
    endfunction

endpackage

// File: rtl/enigma_perm8.sv
// Combinational 8-entry group permuter used to step rotor B.
module enigma_perm8
    import enigma_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic [2:0]        mode_i,
    input  logic [7:0][W-1:0] data_i,
    output logic [7:0][W-1:0] data_o
);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            data_o[k] = data_i[PermTab[mode_i][k]];
        end
    end

endmodule

// File: rtl/enigma_core_param.sv
// Two-rotor Enigma engine: load/run FSM, rotor storage, 2-cycle cipher pipeline.
module enigma_core_param
    import enigma_pkg::*;
#(
    parameter int unsigned W       = 6,
    parameter int unsigned SHIFT_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic         crypt_mode,
    input  logic         code_valid,
    input  logic [W-1:0] code_in,
    output logic         ready,
    output logic         load_err,
    output logic         out_valid,
    output logic [W-1:0] out_code
);

    localparam int unsigned N    = 2 ** W;
    localparam int unsigned NGRP = N / 8;
    localparam logic [W:0] CntOne  = (W+1)'(1);
    localparam logic [W:0] CntN    = (W+1)'(N);
    localparam logic [W:0] CntFull = (W+1)'(2 * N);

    if (!w_legal(W) || SHIFT_W < 1 || SHIFT_W > W) begin : g_bad_param
        $error("enigma_core_param: W must be 3..8 and SHIFT_W must be 1..W");
    end

    state_e       state_q, state_d;
    logic [W:0]   cnt_q, cnt_d, cnt_inc;
    logic         lv_q, mode_q, err_q, err_d;
    logic         start, load_a, load_b, step;
    logic         in_valid_q, out_valid_q;
    logic [W-1:0] in_code_q, out_code_q;

    logic [N-1:0][W-1:0] rot_a_q, rot_a_d, rot_a_step;
    logic [N-1:0][W-1:0] rot_b_q, rot_b_d, rot_b_step;
    logic [N-1:0]        hit_a, hit_b;
    logic [W-1:0]        oa, ob, r, ib, sym_out, s_ext;
    logic [SHIFT_W-1:0]  s;
    logic [2:0]          m;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lv_q    <= load_valid;
            err_q   <= err_d;
        end
    end

    assign cnt_inc = cnt_q + CntOne;

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    state_d = StLoadA;
                    cnt_d   = CntOne;
                end
            end
            StLoadA, StLoadB: begin
                if (!load_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntFull) begin
                        state_d = StRun;
                    end else if (cnt_inc >= CntN) begin
                        state_d = StLoadB;
                    end else begin
                        state_d = StLoadA;
                    end
                end
            end
            StRun: begin
                // Re-key only on a fresh rising edge so an over-long load is ignored.
                if (load_valid && !lv_q) begin
                    state_d = StLoadA;
                    cnt_d   = CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        ready  = (state_q == StRun);
        start  = (state_q == StIdle && load_valid) ||
                 (state_q == StRun && load_valid && !lv_q);
        load_a = start || (state_q == StLoadA && load_valid);
        load_b = (state_q == StLoadB) && load_valid;
        err_d  = (state_q == StLoadA || state_q == StLoadB) && !load_valid;
    end

    assign load_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            in_code_q   <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
        end else begin
            if (start) begin
                mode_q <= crypt_mode;
            end
            in_valid_q  <= code_valid && ready && !load_valid;
            in_code_q   <= code_in;
            out_valid_q <= in_valid_q;
            if (in_valid_q) begin
                out_code_q <= sym_out;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;

    // Forward through A and B, reflect, then invert B and A via one-hot search.
    always_comb begin
        oa = rot_a_q[in_code_q];
        ob = rot_b_q[oa];
        r  = ~ob;
        ib = '0;
        for (int i = 0; i < N; i++) begin
            hit_b[i] = (rot_b_q[i] == r);
            if (hit_b[i]) begin
                ib = ib | W'(i);
            end
        end
        sym_out = '0;
        for (int j = 0; j < N; j++) begin
            hit_a[j] = (rot_a_q[j] == ib);
            if (hit_a[j]) begin
                sym_out = sym_out | W'(j);
            end
        end
    end

    // Step selectors come from mirrored points so decrypt tracks encrypt.
    always_comb begin
        if (mode_q) begin
            s = ib[SHIFT_W-1:0];
            m = r[2:0];
        end else begin
            s = oa[SHIFT_W-1:0];
            m = ob[2:0];
        end
        s_ext = W'(s);
        for (int i = 0; i < N; i++) begin
            rot_a_step[i] = rot_a_q[W'(i) - s_ext];
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        enigma_perm8 #(
            .W (W)
        ) u_perm (
            .mode_i (m),
            .data_i (rot_b_q[g*8 +: 8]),
            .data_o (rot_b_step[g*8 +: 8])
        );
    end

    assign step = in_valid_q && !load_a && !load_b;

    always_comb begin
        rot_a_d = rot_a_q;
        rot_b_d = rot_b_q;
        if (load_a) begin
            rot_a_d = {code_in, rot_a_q[N-1:1]};
        end else if (step) begin
            rot_a_d = rot_a_step;
        end
        if (load_b) begin
            rot_b_d = {code_in, rot_b_q[N-1:1]};
        end else if (step) begin
            rot_b_d = rot_b_step;
        end
    end

    always_ff @(posedge clk) begin
        rot_a_q <= rot_a_d;
        rot_b_q <= rot_b_d;
    end

endmodule
